// File: rtl/sdbp_frame_rx.sv
// -----------------------------------------------------------------------------
// sdbp_frame_rx
//
// Receives the SDBP write burst (sdbpflag / wtaddr / wtdina) sent by the
// backlight frame writer once per refresh period. It assembles the N_LED zone
// brightness words into the hidden half of a ping-pong frame store. A bank swap
// publishes the new frame only after every zone 0..N_LED-1 has arrived in
// order, so the serializer never sees a partial frame.
//
// Ports
//   clk        in   system clock (writer clock domain)
//   rst        in   synchronous, active-high reset
//   sdbpflag   in   frame-start strobe; its rising edge starts a frame
//   wtaddr     in   zone address from the writer
//   wtdina     in   zone data; arrives one cycle after its wtaddr
//   rd_en      in   read request from the serializer
//   rd_addr    in   zone index to read
//   rd_data    out  word from the published bank; valid the cycle after rd_en
//   frame_done out  one-cycle pulse on each bank swap
//   busy       out  frame capture or commit in progress
//   bank_sel   out  bank currently published to the read port
//   frame_cnt  out  committed frames (wraps)
//   err_cnt    out  aborted frames (saturates at 255)
// -----------------------------------------------------------------------------
module sdbp_frame_rx #(
  parameter int N_LED   = 360,
  parameter int DW      = 16,
  parameter int AW      = 10,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sdbpflag,
  input  logic [AW-1:0] wtaddr,
  input  logic [DW-1:0] wtdina,
  input  logic          rd_en,
  input  logic [8:0]    rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          frame_done,
  output logic          busy,
  output logic          bank_sel,
  output logic [15:0]   frame_cnt,
  output logic [7:0]    err_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_COMMIT
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [AW-1:0]   r_wtaddr_q;
  logic            r_sdbpflag_q;
  logic [8:0]      r_exp_idx;
  logic [TW-1:0]   r_timer;
  logic [DW-1:0]   r_rd_data;
  logic            r_frame_done;
  logic            r_busy;
  logic            r_bank_sel;
  logic [15:0]     r_frame_cnt;
  logic [7:0]      r_err_cnt;

  logic [DW-1:0]   r_mem0 [N_LED];
  logic [DW-1:0]   r_mem1 [N_LED];

  logic            w_start;
  logic            w_in_range;
  logic            w_hit_exp;
  logic            w_hit_prev;
  logic [8:0]      w_wr_idx;
  logic [8:0]      w_exp_nxt;
  logic [TW-1:0]   w_timer_nxt;
  logic            w_wr_en;
  logic            w_err_inc;

  // wtdina lags wtaddr by one cycle, so the registered address pairs with the
  // live data word.
  assign w_start    = sdbpflag & ~r_sdbpflag_q;
  assign w_in_range = (r_wtaddr_q < AW'(N_LED));
  assign w_hit_exp  = (r_wtaddr_q == AW'(r_exp_idx));
  // A repeat of the previous index is a legal rewrite (last write wins).
  assign w_hit_prev = (r_exp_idx != 9'd0) && (r_wtaddr_q == AW'(r_exp_idx - 9'd1));
  assign w_wr_idx   = r_wtaddr_q[8:0];

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked process uses non-blocking (<=) so all registers sample
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and capture control
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    w_state_nxt = r_state;
    w_exp_nxt   = r_exp_idx;
    w_timer_nxt = r_timer;
    w_wr_en     = 1'b0;
    w_err_inc   = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_CAPTURE;
          w_exp_nxt   = 9'd0;
          w_timer_nxt = '0;
        end
      end

      S_CAPTURE: begin
        w_timer_nxt = r_timer + TW'(1);
        if (w_start) begin
          // A new frame start overrides anything else happening this cycle.
          w_err_inc   = 1'b1;
          w_exp_nxt   = 9'd0;
          w_timer_nxt = '0;
        end else if (r_timer == TW'(TIMEOUT - 1)) begin
          w_err_inc   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_in_range) begin
          if (w_hit_exp) begin
            w_wr_en   = 1'b1;
            w_exp_nxt = r_exp_idx + 9'd1;
            if (r_exp_idx == 9'(N_LED - 1)) begin
              w_state_nxt = S_COMMIT;
            end
          end else if (w_hit_prev) begin
            w_wr_en = 1'b1;
          end else begin
            w_err_inc   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end

      S_COMMIT: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and status registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wtaddr_q   <= '0;
      r_sdbpflag_q <= 1'b0;
      r_exp_idx    <= 9'd0;
      r_timer      <= '0;
      r_rd_data    <= '0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
      r_bank_sel   <= 1'b0;
      r_frame_cnt  <= 16'd0;
      r_err_cnt    <= 8'd0;
    end else begin
      r_wtaddr_q   <= wtaddr;
      r_sdbpflag_q <= sdbpflag;
      r_exp_idx    <= w_exp_nxt;
      r_timer      <= w_timer_nxt;
      // busy/frame_done trail the state by one cycle so they are glitch-free.
      r_busy       <= (r_state != S_IDLE);
      r_frame_done <= (r_state == S_COMMIT);

      if (r_state == S_COMMIT) begin
        r_bank_sel  <= ~r_bank_sel;
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end

      if (w_err_inc && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end

      // Reads use the pre-swap bank_sel during the commit cycle.
      if (rd_en) begin
        if (rd_addr < 9'(N_LED)) begin
          r_rd_data <= r_bank_sel ? r_mem1[rd_addr] : r_mem0[rd_addr];
        end else begin
          r_rd_data <= '0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame store: writes always target the hidden bank (~bank_sel)
  // ---------------------------------------------------------------------------
  // NOTE: the arrays are deliberately not reset; a frame is only visible after
  // a full commit overwrites every entry, so clearing them buys nothing.
  always_ff @(posedge clk) begin
    if (w_wr_en && !rst) begin
      if (r_bank_sel) begin
        r_mem0[w_wr_idx] <= wtdina;
      end else begin
        r_mem1[w_wr_idx] <= wtdina;
      end
    end
  end

  assign rd_data    = r_rd_data;
  assign frame_done = r_frame_done;
  assign busy       = r_busy;
  assign bank_sel   = r_bank_sel;
  assign frame_cnt  = r_frame_cnt;
  assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_sdbp_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_sdbp_frame_rx
//
// Self-checking bench for sdbp_frame_rx. Writer traffic is generated one cycle
// at a time by step(); read expectations go into a scoreboard queue when the
// read is issued and are compared when rd_data becomes valid. Inputs change and
// outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_sdbp_frame_rx;

  localparam int         N_LED  = 360;
  localparam logic [9:0] IDLE_A = 10'd1023;  // out-of-range address: ignored

  logic        clk = 1'b0;
  logic        rst;
  logic        sdbpflag;
  logic [9:0]  wtaddr;
  logic [15:0] wtdina;
  logic        rd_en;
  logic [8:0]  rd_addr;
  logic [15:0] rd_data;
  logic        frame_done;
  logic        busy;
  logic        bank_sel;
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;
  int          exp_done = 0;
  logic [15:0] pend_data = 16'h0;
  logic        rd_pend;

  typedef struct {
    logic [8:0]  addr;
    logic [15:0] data;
  } rd_exp_t;

  rd_exp_t sb_q[$];
  rd_exp_t nom_tab[8];

  sdbp_frame_rx #(
    .N_LED   (360),
    .DW      (16),
    .AW      (10),
    .TIMEOUT (1024)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sdbpflag   (sdbpflag),
    .wtaddr     (wtaddr),
    .wtdina     (wtdina),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .frame_done (frame_done),
    .busy       (busy),
    .bank_sel   (bank_sel),
    .frame_cnt  (frame_cnt),
    .err_cnt    (err_cnt)
  );

  always #20 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // frame_done pulse counter
  always @(negedge clk) begin
    if (frame_done === 1'b1) done_cnt++;
  end

  // Read scoreboard: pop and compare one cycle after each accepted read.
  always @(posedge clk) rd_pend <= rd_en;

  always @(negedge clk) begin
    if (rd_pend === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: got read data 0x%0h with no expected entry", rd_data);
      end else begin
        rd_exp_t e;
        e = sb_q.pop_front();
        check($sformatf("rd_data[%0d]", e.addr), 32'(rd_data), 32'(e.data));
      end
    end
  end

  // One writer cycle: wtdina carries the data belonging to the previous wtaddr.
  task automatic step(input logic flag, input logic [9:0] addr, input logic [15:0] data);
    sdbpflag  = flag;
    wtaddr    = addr;
    wtdina    = pend_data;
    pend_data = data;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic flag_pulse(input int n);
    for (int i = 0; i < n; i++) step(1'b1, IDLE_A, 16'h0);
  endtask

  task automatic send_words(input logic [15:0] base, input int first, input int last);
    for (int i = first; i <= last; i++) step(1'b0, 10'(i), base + 16'(i));
  endtask

  task automatic read_req(input logic [8:0] addr, input logic [15:0] exp);
    rd_exp_t e;
    e.addr  = addr;
    e.data  = exp;
    sb_q.push_back(e);
    rd_en   = 1'b1;
    rd_addr = addr;
    step(1'b0, IDLE_A, 16'h0);
    rd_en   = 1'b0;
  endtask

  // Flush the last data word, then walk through the commit cycle checking the
  // exact swap timing. Optionally issue a read during the commit cycle, which
  // must still see the old bank.
  task automatic end_frame(input logic do_read, input logic [8:0] raddr,
                           input logic [15:0] old_exp, input logic new_bank);
    step(1'b0, IDLE_A, 16'h0);
    check("done_before_commit", 32'(frame_done), 32'd0);
    check("busy_before_commit", 32'(busy), 32'd1);
    if (do_read) read_req(raddr, old_exp);
    else step(1'b0, IDLE_A, 16'h0);
    check("frame_done_pulse", 32'(frame_done), 32'd1);
    check("bank_sel_swap", 32'(bank_sel), 32'(new_bank));
    exp_done++;
    step(1'b0, IDLE_A, 16'h0);
    check("frame_done_clear", 32'(frame_done), 32'd0);
    check("busy_after_commit", 32'(busy), 32'd0);
  endtask

  initial begin
    nom_tab[0] = '{addr: 9'd0,   data: 16'h1000};
    nom_tab[1] = '{addr: 9'd1,   data: 16'h1001};
    nom_tab[2] = '{addr: 9'd100, data: 16'h1064};
    nom_tab[3] = '{addr: 9'd360, data: 16'h0000};
    nom_tab[4] = '{addr: 9'd511, data: 16'h0000};
    nom_tab[5] = '{addr: 9'd200, data: 16'h10C8};
    nom_tab[6] = '{addr: 9'd358, data: 16'h1166};
    nom_tab[7] = '{addr: 9'd359, data: 16'h1167};

    rst      = 1'b1;
    sdbpflag = 1'b0;
    wtaddr   = IDLE_A;
    wtdina   = 16'h0;
    rd_en    = 1'b0;
    rd_addr  = 9'd0;

    // ---------------- reset values ----------------
    @(negedge clk);
    step(1'b0, IDLE_A, 16'h0);
    step(1'b0, IDLE_A, 16'h0);
    check("rst_rd_data",    32'(rd_data),    32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_bank_sel",   32'(bank_sel),   32'd0);
    check("rst_frame_cnt",  32'(frame_cnt),  32'd0);
    check("rst_err_cnt",    32'(err_cnt),    32'd0);
    rst = 1'b0;
    step(1'b0, IDLE_A, 16'h0);

    // ---------------- nominal frame ----------------
    flag_pulse(1);
    check("busy_one_cycle_after_start", 32'(busy), 32'd0);
    flag_pulse(29);
    check("busy_in_capture", 32'(busy), 32'd1);
    send_words(16'h1000, 0, N_LED - 1);
    end_frame(1'b0, 9'd0, 16'h0, 1'b1);
    check("nom_frame_cnt", 32'(frame_cnt), 32'd1);
    check("nom_err_cnt",   32'(err_cnt),   32'd0);
    check("nom_done_cnt",  32'(done_cnt),  32'(exp_done));
    foreach (nom_tab[i]) read_req(nom_tab[i].addr, nom_tab[i].data);
    rd_addr = 9'd5;
    step(1'b0, IDLE_A, 16'h0);
    check("rd_hold", 32'(rd_data), 32'h1167);

    // ---------------- rewrite of index 0 ----------------
    flag_pulse(5);
    step(1'b0, 10'd0, 16'h0000);
    step(1'b0, 10'd0, 16'h0000);
    step(1'b0, 10'd0, 16'hABCD);
    send_words(16'h2000, 1, N_LED - 1);
    end_frame(1'b1, 9'd0, 16'h1000, 1'b0);
    check("rew_frame_cnt", 32'(frame_cnt), 32'd2);
    check("rew_done_cnt",  32'(done_cnt),  32'(exp_done));
    read_req(9'd0,   16'hABCD);
    read_req(9'd1,   16'h2001);
    read_req(9'd359, 16'h2167);

    // ---------------- skipped index ----------------
    flag_pulse(5);
    send_words(16'h3000, 0, 99);
    step(1'b0, 10'd101, 16'h3065);
    step(1'b0, IDLE_A, 16'h0);
    step(1'b0, IDLE_A, 16'h0);
    step(1'b0, IDLE_A, 16'h0);
    check("skip_err_cnt",   32'(err_cnt),   32'd1);
    check("skip_busy",      32'(busy),      32'd0);
    check("skip_bank_sel",  32'(bank_sel),  32'd0);
    check("skip_frame_cnt", 32'(frame_cnt), 32'd2);
    check("skip_done_cnt",  32'(done_cnt),  32'(exp_done));
    read_req(9'd0,   16'hABCD);
    read_req(9'd100, 16'h2064);

    // ---------------- restart mid-frame ----------------
    flag_pulse(5);
    send_words(16'h4000, 0, 200);
    flag_pulse(5);
    check("restart_err_cnt", 32'(err_cnt), 32'd2);
    check("restart_busy",    32'(busy),    32'd1);
    send_words(16'h5000, 0, N_LED - 1);
    end_frame(1'b1, 9'd10, 16'h200A, 1'b1);
    check("restart_frame_cnt", 32'(frame_cnt), 32'd3);
    check("restart_err_after", 32'(err_cnt),   32'd2);
    check("restart_done_cnt",  32'(done_cnt),  32'(exp_done));
    for (int i = 0; i < N_LED; i++) read_req(9'(i), 16'h5000 + 16'(i));

    // ---------------- timeout ----------------
    for (int i = 0; i < 1100; i++) begin
      step(i < 5, 10'd0, 16'h0);
      if (i == 1023) check("timeout_not_yet", 32'(err_cnt), 32'd2);
      if (i == 1024) check("timeout_err_cnt", 32'(err_cnt), 32'd3);
    end
    check("timeout_busy",      32'(busy),      32'd0);
    check("timeout_bank_sel",  32'(bank_sel),  32'd1);
    check("timeout_frame_cnt", 32'(frame_cnt), 32'd3);
    check("timeout_done_cnt",  32'(done_cnt),  32'(exp_done));

    // ---------------- reset mid-capture ----------------
    flag_pulse(5);
    send_words(16'h6000, 0, 150);
    rst = 1'b1;
    step(1'b0, IDLE_A, 16'h0);
    step(1'b0, IDLE_A, 16'h0);
    rst = 1'b0;
    check("mrst_bank_sel",   32'(bank_sel),   32'd0);
    check("mrst_frame_cnt",  32'(frame_cnt),  32'd0);
    check("mrst_err_cnt",    32'(err_cnt),    32'd0);
    check("mrst_busy",       32'(busy),       32'd0);
    check("mrst_rd_data",    32'(rd_data),    32'd0);
    step(1'b0, IDLE_A, 16'h0);
    flag_pulse(5);
    send_words(16'h7000, 0, N_LED - 1);
    end_frame(1'b0, 9'd0, 16'h0, 1'b1);
    check("post_rst_frame_cnt", 32'(frame_cnt), 32'd1);
    check("post_rst_err_cnt",   32'(err_cnt),   32'd0);
    check("post_rst_done_cnt",  32'(done_cnt),  32'(exp_done));
    for (int i = 0; i < N_LED; i += 7) read_req(9'(i), 16'h7000 + 16'(i));
    read_req(9'd359, 16'h7167);

    // ---------------- err_cnt saturation ----------------
    for (int i = 0; i < 300; i++) begin
      step(1'b1, IDLE_A, 16'h0);
      step(1'b0, IDLE_A, 16'h0);
    end
    check("err_cnt_saturate", 32'(err_cnt), 32'd255);
    check("sat_frame_cnt",    32'(frame_cnt), 32'd1);

    step(1'b0, IDLE_A, 16'h0);
    step(1'b0, IDLE_A, 16'h0);
    check("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
